// File: rtl/riscv_mul_writeback.sv
// -----------------------------------------------------------------------------
// riscv_mul_writeback
//   Writeback stage that sits behind riscv_multiplier. Each issued
//   instruction's destination is carried through a two-stage tag pipeline
//   (S1, S2) whose depth matches the multiplier latency. In S2 the late
//   multiply result is merged with the ALU result and drives the
//   register-file write port in program order. RAW hazards against
//   destinations still in flight are detected at issue, and retired
//   instructions are counted.
//
//   Optional feature macro: WB_BYPASS_EN
//     defined   : ALU results in S1 and any result in S2 are forwarded to the
//                 issuing instruction's operands; only a dependency on a
//                 multiply still in S1 stalls.
//     undefined : no forwarding; any dependency on S1 or S2 stalls.
//
// Ports
//   clk, rst          core clock, synchronous active-high reset
//   hold              global freeze (shared with riscv_multiplier)
//   valid_i           instruction issued this cycle
//   opcode_i          instruction word, used to classify multiplies
//   rd/ra/rb_idx_i    destination and source register indices
//   ra_rf_i, rb_rf_i  register-file read data for ra/rb
//   alu_result_i      non-multiply result, valid in the issue cycle
//   mul_result_i      multiplier result, valid when the op sits in S2
//   ra/rb_value_o     operands after hazard resolution
//   stall_o           issuing instruction must not proceed
//   rf_we/waddr/wdata register-file write port
//   instret_o         retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module riscv_mul_writeback #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold,
   input  logic             valid_i,
   input  logic [31:0]      opcode_i,
   input  logic [4:0]       rd_idx_i,
   input  logic [4:0]       ra_idx_i,
   input  logic [4:0]       rb_idx_i,
   input  logic [XLEN-1:0]  ra_rf_i,
   input  logic [XLEN-1:0]  rb_rf_i,
   input  logic [XLEN-1:0]  alu_result_i,
   input  logic [XLEN-1:0]  mul_result_i,
   output logic [XLEN-1:0]  ra_value_o,
   output logic [XLEN-1:0]  rb_value_o,
   output logic             stall_o,
   output logic             rf_we_o,
   output logic [4:0]       rf_waddr_o,
   output logic [XLEN-1:0]  rf_wdata_o,
   output logic [CNT_W-1:0] instret_o
);

   // ---------------------------------------------------------------------------
   // Pipeline state
   // ---------------------------------------------------------------------------
   logic             v1_q,   v1_d;
   logic [4:0]       rd1_q,  rd1_d;
   logic             mul1_q, mul1_d;
   logic [XLEN-1:0]  alu1_q, alu1_d;

   logic             v2_q,   v2_d;
   logic [4:0]       rd2_q,  rd2_d;
   logic             mul2_q, mul2_d;
   logic [XLEN-1:0]  data2_q, data2_d;

   logic [CNT_W-1:0] instret_q, instret_d;

   // Only the major opcode, funct7 and the top funct3 bit classify a multiply
   // (funct3[2]==1 selects the divide/remainder family).
   logic unused_opcode_bits;
   assign unused_opcode_bits = ^{opcode_i[24:15], opcode_i[13:7]};

   logic is_mul;
   assign is_mul = (opcode_i[6:0] == 7'b0110011) &&
                   (opcode_i[31:25] == 7'b0000001) &&
                   !opcode_i[14];

   // ---------------------------------------------------------------------------
   // Hazard detection. x0 is never a real destination, so rd!=0 is part of
   // every match; that also keeps a source of x0 from ever matching.
   // ---------------------------------------------------------------------------
   logic hit_a1, hit_b1, hit_a2, hit_b2;
   assign hit_a1 = v1_q && (rd1_q != 5'd0) && (rd1_q == ra_idx_i);
   assign hit_b1 = v1_q && (rd1_q != 5'd0) && (rd1_q == rb_idx_i);
   assign hit_a2 = v2_q && (rd2_q != 5'd0) && (rd2_q == ra_idx_i);
   assign hit_b2 = v2_q && (rd2_q != 5'd0) && (rd2_q == rb_idx_i);

   // ---------------------------------------------------------------------------
   // Write port: the multiply result only becomes valid once the op is in S2,
   // so the merge happens here rather than at issue.
   // ---------------------------------------------------------------------------
   assign rf_wdata_o = mul2_q ? mul_result_i : data2_q;
   assign rf_waddr_o = rd2_q;
   // Gating with ~hold makes a frozen S2 write once, on the release cycle.
   assign rf_we_o    = v2_q && (rd2_q != 5'd0) && !hold;
   assign instret_o  = instret_q;

`ifdef WB_BYPASS_EN
   // A multiply in S1 has no result yet, so it is the only unresolvable case.
   assign stall_o = valid_i && ((hit_a1 && mul1_q) || (hit_b1 && mul1_q));

   // S1 is younger than S2, so it is checked first. A multiply hit in S1
   // falls through to the lower priorities, but stall_o is raised anyway.
   always_comb begin
      ra_value_o = ra_rf_i;
      if (hit_a1 && !mul1_q)
         ra_value_o = alu1_q;
      else if (hit_a2)
         ra_value_o = rf_wdata_o;
   end

   always_comb begin
      rb_value_o = rb_rf_i;
      if (hit_b1 && !mul1_q)
         rb_value_o = alu1_q;
      else if (hit_b2)
         rb_value_o = rf_wdata_o;
   end
`else
   assign stall_o    = valid_i && (hit_a1 || hit_b1 || hit_a2 || hit_b2);
   assign ra_value_o = ra_rf_i;
   assign rb_value_o = rb_rf_i;
`endif

   // ---------------------------------------------------------------------------
   // Next state. A stalled issue enters S1 as a bubble; the other S1 fields
   // are captured unconditionally since they are qualified by v1.
   // ---------------------------------------------------------------------------
   logic acc;
   assign acc = valid_i && !stall_o;

   always_comb begin
      v1_d      = v1_q;
      rd1_d     = rd1_q;
      mul1_d    = mul1_q;
      alu1_d    = alu1_q;
      v2_d      = v2_q;
      rd2_d     = rd2_q;
      mul2_d    = mul2_q;
      data2_d   = data2_q;
      instret_d = instret_q;
      if (!hold) begin
         v1_d    = acc;
         rd1_d   = rd_idx_i;
         mul1_d  = is_mul;
         alu1_d  = alu_result_i;
         v2_d    = v1_q;
         rd2_d   = rd1_q;
         mul2_d  = mul1_q;
         data2_d = alu1_q;
         // x0 destinations still retire, so count on v2 alone.
         if (v2_q)
            instret_d = instret_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q      <= 1'b0;
         rd1_q     <= 5'd0;
         mul1_q    <= 1'b0;
         alu1_q    <= '0;
         v2_q      <= 1'b0;
         rd2_q     <= 5'd0;
         mul2_q    <= 1'b0;
         data2_q   <= '0;
         instret_q <= '0;
      end else begin
         v1_q      <= v1_d;
         rd1_q     <= rd1_d;
         mul1_q    <= mul1_d;
         alu1_q    <= alu1_d;
         v2_q      <= v2_d;
         rd2_q     <= rd2_d;
         mul2_q    <= mul2_d;
         data2_q   <= data2_d;
         instret_q <= instret_d;
      end
   end

endmodule

// File: tb/tb_riscv_mul_writeback.sv
// -----------------------------------------------------------------------------
// tb_riscv_mul_writeback
//   Directed bench: a vector table for single-instruction flows, followed by
//   hand-written sequences for dependencies, hold and mid-pipeline reset.
//   Expectations for the dependency cases differ with WB_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_riscv_mul_writeback;

   localparam logic [31:0] OP_ADDI = 32'h0000_0013;
   localparam logic [31:0] OP_ADD  = 32'h0000_0033;
   localparam logic [31:0] OP_MUL  = 32'h0200_0033;
   localparam logic [31:0] OP_DIV  = 32'h0200_4033;

   logic        clk = 1'b1;
   logic        rst, hold, valid_i;
   logic [31:0] opcode_i;
   logic [4:0]  rd_idx_i, ra_idx_i, rb_idx_i;
   logic [31:0] ra_rf_i, rb_rf_i, alu_result_i, mul_result_i;
   logic [31:0] ra_value_o, rb_value_o, rf_wdata_o, instret_o;
   logic        stall_o, rf_we_o;
   logic [4:0]  rf_waddr_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   riscv_mul_writeback #(.XLEN(32), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .hold(hold), .valid_i(valid_i),
      .opcode_i(opcode_i), .rd_idx_i(rd_idx_i), .ra_idx_i(ra_idx_i),
      .rb_idx_i(rb_idx_i), .ra_rf_i(ra_rf_i), .rb_rf_i(rb_rf_i),
      .alu_result_i(alu_result_i), .mul_result_i(mul_result_i),
      .ra_value_o(ra_value_o), .rb_value_o(rb_value_o), .stall_o(stall_o),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .instret_o(instret_o)
   );

   typedef struct {
      logic        rst, valid;
      logic [31:0] op;
      logic [4:0]  rd, ra, rb;
      logic [31:0] rarf, rbrf, alu, mul;
      logic        chk, e_we;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
      logic        e_st;
      logic [31:0] e_ra, e_rb, e_cnt;
   } vec_t;

   function automatic vec_t mk(
      input logic rst_, input logic valid_, input logic [31:0] op_,
      input logic [4:0] rd_, input logic [4:0] ra_, input logic [4:0] rb_,
      input logic [31:0] rarf_, input logic [31:0] rbrf_,
      input logic [31:0] alu_, input logic [31:0] mul_,
      input logic chk_, input logic we_, input logic [4:0] wa_,
      input logic [31:0] wd_, input logic st_, input logic [31:0] era_,
      input logic [31:0] erb_, input logic [31:0] cnt_);
      vec_t v;
      v.rst = rst_; v.valid = valid_; v.op = op_; v.rd = rd_; v.ra = ra_;
      v.rb = rb_; v.rarf = rarf_; v.rbrf = rbrf_; v.alu = alu_; v.mul = mul_;
      v.chk = chk_; v.e_we = we_; v.e_wa = wa_; v.e_wd = wd_; v.e_st = st_;
      v.e_ra = era_; v.e_rb = erb_; v.e_cnt = cnt_;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic h, input logic v,
                        input logic [31:0] op, input logic [4:0] rd,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic [31:0] rarf, input logic [31:0] rbrf,
                        input logic [31:0] alu, input logic [31:0] mul);
      rst = r; hold = h; valid_i = v; opcode_i = op; rd_idx_i = rd;
      ra_idx_i = ra; rb_idx_i = rb; ra_rf_i = rarf; rb_rf_i = rbrf;
      alu_result_i = alu; mul_result_i = mul;
   endtask

   task automatic idle();
      drive(0, 0, 0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
   endtask

   // Outputs are sampled on the falling edge; the next vector is applied just
   // after the rising edge.
   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[16];

   initial begin
      tbl[0]  = mk(1,1,OP_ADDI,5,0,0,0,0,32'hAAAA,0,   0, 0,0,0,0,0,0,0);
      tbl[1]  = mk(1,1,OP_ADDI,5,0,0,0,0,32'hAAAA,0,   1, 0,0,0,0,0,0,0);
      tbl[2]  = mk(0,1,OP_ADDI,5,1,2,32'h11,32'h22,32'h1234,0,
                   1, 0,0,0,0,32'h11,32'h22,0);
      tbl[3]  = mk(0,0,0,0,0,0,0,0,0,0,                 1, 0,0,0,0,0,0,0);
      tbl[4]  = mk(0,0,0,0,0,0,0,0,0,0,                 1, 1,5,32'h1234,0,0,0,0);
      tbl[5]  = mk(0,1,OP_MUL,7,3,4,6,7,32'h5555,0,     1, 0,0,0,0,6,7,1);
      tbl[6]  = mk(0,0,0,0,0,0,0,0,0,32'h99,            1, 0,0,0,0,0,0,1);
      tbl[7]  = mk(0,0,0,0,0,0,0,0,0,42,                1, 1,7,42,0,0,0,1);
      tbl[8]  = mk(0,1,OP_ADDI,0,0,0,0,0,32'h33,0,      1, 0,0,0,0,0,0,2);
      tbl[9]  = mk(0,1,OP_ADD,9,0,0,5,6,32'h44,0,       1, 0,0,0,0,5,6,2);
      tbl[10] = mk(0,0,0,0,0,0,0,0,0,0,                 1, 0,0,32'h33,0,0,0,2);
      tbl[11] = mk(0,0,0,0,0,0,0,0,0,0,                 1, 1,9,32'h44,0,0,0,3);
      tbl[12] = mk(0,1,OP_DIV,10,0,0,0,0,32'hD1,0,      1, 0,0,0,0,0,0,4);
      tbl[13] = mk(0,0,0,0,0,0,0,0,0,32'hBAD,           1, 0,0,0,0,0,0,4);
      tbl[14] = mk(0,0,0,0,0,0,0,0,0,32'hBAD,           1, 1,10,32'hD1,0,0,0,4);
      tbl[15] = mk(0,0,0,0,0,0,0,0,0,0,                 1, 0,0,0,0,0,0,5);

      // ---------------- table ----------------
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].rst, 0, tbl[i].valid, tbl[i].op, tbl[i].rd, tbl[i].ra,
               tbl[i].rb, tbl[i].rarf, tbl[i].rbrf, tbl[i].alu, tbl[i].mul);
         to_neg();
         if (tbl[i].chk) begin
            chk($sformatf("r%0d we", i),    {31'd0, rf_we_o},    {31'd0, tbl[i].e_we});
            chk($sformatf("r%0d waddr", i), {27'd0, rf_waddr_o}, {27'd0, tbl[i].e_wa});
            chk($sformatf("r%0d wdata", i), rf_wdata_o,          tbl[i].e_wd);
            chk($sformatf("r%0d stall", i), {31'd0, stall_o},    {31'd0, tbl[i].e_st});
            chk($sformatf("r%0d ra", i),    ra_value_o,          tbl[i].e_ra);
            chk($sformatf("r%0d rb", i),    rb_value_o,          tbl[i].e_rb);
            chk($sformatf("r%0d instret", i), instret_o,         tbl[i].e_cnt);
         end
         to_pos();
      end

      // ---------------- MUL rd7 -> dependent ADD ra7 ----------------
      drive(0,0,1,OP_MUL,7,3,4,6,7,0,0);
      to_neg(); chk("depA a stall", {31'd0, stall_o}, 0); to_pos();
      drive(0,0,1,OP_ADD,8,7,2,32'h100,5,32'h77,0);
      to_neg();
      chk("depA b stall", {31'd0, stall_o}, 1);
      chk("depA b ra", ra_value_o, 32'h100);
      chk("depA b we", {31'd0, rf_we_o}, 0);
      to_pos();
      drive(0,0,1,OP_ADD,8,7,2,32'h100,5,32'h77,42);
      to_neg();
      chk("depA c we", {31'd0, rf_we_o}, 1);
      chk("depA c waddr", {27'd0, rf_waddr_o}, 7);
      chk("depA c wdata", rf_wdata_o, 42);
      chk("depA c rb", rb_value_o, 5);
`ifdef WB_BYPASS_EN
      chk("depA c stall", {31'd0, stall_o}, 0);
      chk("depA c ra fwd", ra_value_o, 42);
      to_pos();
      idle();
      to_neg(); chk("depA d stall", {31'd0, stall_o}, 0);
      chk("depA d we", {31'd0, rf_we_o}, 0);
      to_pos();
`else
      chk("depA c stall", {31'd0, stall_o}, 1);
      chk("depA c ra", ra_value_o, 32'h100);
      to_pos();
      drive(0,0,1,OP_ADD,8,7,2,42,5,32'h77,0);
      to_neg(); chk("depA d stall", {31'd0, stall_o}, 0);
      chk("depA d ra", ra_value_o, 42);
      chk("depA d we", {31'd0, rf_we_o}, 0);
      to_pos();
`endif
      idle();
      repeat (3) to_pos();
      to_neg(); chk("depA instret", instret_o, 7); to_pos();

      // ---------------- ALU rd5 -> dependent ADD rb5 ----------------
      drive(0,0,1,OP_ADDI,5,0,0,0,0,32'h1234,0);
      to_neg(); chk("depB a stall", {31'd0, stall_o}, 0); to_pos();
      drive(0,0,1,OP_ADD,6,1,5,32'h10,32'h20,0,0);
      to_neg();
      chk("depB b ra", ra_value_o, 32'h10);
`ifdef WB_BYPASS_EN
      chk("depB b stall", {31'd0, stall_o}, 0);
      chk("depB b rb fwd", rb_value_o, 32'h1234);
      to_pos();
      idle();
      to_neg();
      chk("depB c we", {31'd0, rf_we_o}, 1);
      chk("depB c waddr", {27'd0, rf_waddr_o}, 5);
      chk("depB c wdata", rf_wdata_o, 32'h1234);
      to_pos();
`else
      chk("depB b stall", {31'd0, stall_o}, 1);
      chk("depB b rb", rb_value_o, 32'h20);
      to_pos();
      to_neg();
      chk("depB c stall", {31'd0, stall_o}, 1);
      chk("depB c we", {31'd0, rf_we_o}, 1);
      chk("depB c waddr", {27'd0, rf_waddr_o}, 5);
      chk("depB c wdata", rf_wdata_o, 32'h1234);
      to_pos();
      to_neg(); chk("depB d stall", {31'd0, stall_o}, 0);
      chk("depB d we", {31'd0, rf_we_o}, 0);
      to_pos();
`endif
      idle();
      repeat (3) to_pos();
      to_neg(); chk("depB instret", instret_o, 9); to_pos();

      // ---------------- hold with v2=1, dependent issue pending ----------------
      drive(0,0,1,OP_ADDI,12,0,0,0,0,32'hABC,0);
      to_pos();
      idle();
      to_pos();
      for (int h = 0; h < 3; h++) begin
         drive(0,1,1,OP_ADD,13,12,0,1,0,32'h999,0);
         to_neg();
         chk($sformatf("hold%0d we", h), {31'd0, rf_we_o}, 0);
         chk($sformatf("hold%0d waddr", h), {27'd0, rf_waddr_o}, 12);
         chk($sformatf("hold%0d wdata", h), rf_wdata_o, 32'hABC);
         chk($sformatf("hold%0d instret", h), instret_o, 9);
`ifdef WB_BYPASS_EN
         chk($sformatf("hold%0d stall", h), {31'd0, stall_o}, 0);
         chk($sformatf("hold%0d ra fwd", h), ra_value_o, 32'hABC);
`else
         chk($sformatf("hold%0d stall", h), {31'd0, stall_o}, 1);
         chk($sformatf("hold%0d ra", h), ra_value_o, 1);
`endif
         to_pos();
      end
      idle();
      to_neg();
      chk("release we", {31'd0, rf_we_o}, 1);
      chk("release waddr", {27'd0, rf_waddr_o}, 12);
      chk("release wdata", rf_wdata_o, 32'hABC);
      chk("release instret", instret_o, 9);
      to_pos();
      to_neg();
      chk("post-release we", {31'd0, rf_we_o}, 0);
      chk("post-release waddr", {27'd0, rf_waddr_o}, 0);
      chk("post-release instret", instret_o, 10);
      to_pos();

      // ---------------- reset mid-pipeline ----------------
      drive(0,0,1,OP_ADDI,5,0,0,0,0,32'h55,0);
      to_pos();
      drive(1,0,1,OP_ADDI,6,0,0,0,0,32'h66,0);
      to_pos();
      idle();
      to_neg();
      chk("midrst we", {31'd0, rf_we_o}, 0);
      chk("midrst waddr", {27'd0, rf_waddr_o}, 0);
      chk("midrst wdata", rf_wdata_o, 0);
      chk("midrst instret", instret_o, 0);
      to_pos();
      to_neg();
      chk("midrst+1 we", {31'd0, rf_we_o}, 0);
      chk("midrst+1 instret", instret_o, 0);
      to_pos();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
